// File: rtl/sign_extend_arbiter.sv
// sign_extend_arbiter: round-robin arbiter sharing one sign-extender, registered tagged result.
// Define SE_ARB_ZERO_EXT_EN to add the per-requester req_zext zero-extend select.
module sign_extend #(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_OUTPUTS = 32
) (
  input  logic [NUM_INPUTS-1:0]  in_data,
  input  logic                   zext,
  output logic [NUM_OUTPUTS-1:0] out_data
);
  if (NUM_OUTPUTS > NUM_INPUTS) begin : g_ext
    assign out_data = {{(NUM_OUTPUTS-NUM_INPUTS){in_data[NUM_INPUTS-1] & ~zext}}, in_data};
  end else begin : g_copy
    assign out_data = in_data;
  end
endmodule

module sign_extend_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_OUTPUTS = 32,
  parameter int ID_W        = ($clog2(NUM_REQ) > 0 ? $clog2(NUM_REQ) : 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*NUM_INPUTS-1:0] req_data,
`ifdef SE_ARB_ZERO_EXT_EN
  input  logic [NUM_REQ-1:0]            req_zext,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [NUM_OUTPUTS-1:0]        out_data,
  output logic [ID_W-1:0]               out_id,
  input  logic                          out_ready
);
  logic [ID_W-1:0]        ptr_q, ptr_d, gidx, off;
  logic [ID_W:0]          sum;
  logic [NUM_REQ-1:0]     rot, grant;
  logic [NUM_INPUTS-1:0]  sel_data;
  logic                   sel_zext, can_accept, xfer;
  logic [NUM_OUTPUTS-1:0] ext, out_data_q, out_data_d;
  logic [ID_W-1:0]        out_id_q, out_id_d;
  logic                   out_valid_q, out_valid_d;
  // Rotate so bit 0 is the requester at ptr; the lowest set bit is the winner's offset.
  assign rot = NUM_REQ'({req_valid, req_valid} >> ptr_q);
  always_comb begin
    off = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) off = rot[k] ? ID_W'(k) : off;
    sum = {1'b0, ptr_q} + {1'b0, off};
    gidx = ID_W'(sum >= (ID_W+1)'(NUM_REQ) ? sum - (ID_W+1)'(NUM_REQ) : sum);
    grant = |req_valid ? NUM_REQ'(1) << gidx : '0;
  end
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      sel_data = sel_data | (req_data[i*NUM_INPUTS +: NUM_INPUTS] & {NUM_INPUTS{grant[i]}});
  end
`ifdef SE_ARB_ZERO_EXT_EN
  assign sel_zext = |(grant & req_zext);
`else
  assign sel_zext = 1'b0;
`endif
  sign_extend #(.NUM_INPUTS(NUM_INPUTS), .NUM_OUTPUTS(NUM_OUTPUTS)) u_se (
    .in_data  (sel_data),
    .zext     (sel_zext),
    .out_data (ext)
  );
  assign can_accept = !out_valid_q || out_ready;
  assign req_ready  = grant & {NUM_REQ{can_accept && !rst}};
  assign xfer       = |req_ready;
  always_comb begin
    out_valid_d = xfer ? 1'b1 : out_valid_q && !out_ready;
    out_data_d  = xfer ? ext : out_data_q;
    out_id_d    = xfer ? gidx : out_id_q;
    ptr_d       = !xfer ? ptr_q : gidx == ID_W'(NUM_REQ-1) ? '0 : gidx + ID_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
endmodule

// File: tb/tb_sign_extend_arbiter.sv
// tb_sign_extend_arbiter: reference-model and scoreboard bench for sign_extend_arbiter (2 requesters).
module tb_sign_extend_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, req_zext = '0;
  logic [31:0] req_data = '0;
  logic        out_valid, out_id, out_ready = 1'b0;
  logic [31:0] out_data;
  int          n_chk = 0, n_pass = 0;
  logic [32:0] sb[$];
  logic        m_valid = 1'b0, m_id = 1'b0, m_ptr = 1'b0;
  logic [31:0] m_data = '0;

  always #5 clk = ~clk;

  sign_extend_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef SE_ARB_ZERO_EXT_EN
    .req_zext  (req_zext),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  function automatic logic [31:0] ext(input logic [15:0] d, input logic z);
`ifdef SE_ARB_ZERO_EXT_EN
    return z ? {16'h0, d} : {{16{d[15]}}, d};
`else
    return {{16{d[15]}}, d};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cyc(input logic rs, input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                     input logic rdy, input logic [1:0] z);
    logic [1:0]  g;
    logic        gi;
    logic [32:0] e;
    @(negedge clk);
    rst = rs; req_valid = v; req_data = {d1, d0}; out_ready = rdy; req_zext = z;
    #1;
    g = '0;
    gi = 1'b0;
    if (!rs && (!m_valid || rdy)) begin
      if (v[m_ptr]) begin gi = m_ptr; g[gi] = 1'b1; end
      else if (v[!m_ptr]) begin gi = !m_ptr; g[gi] = 1'b1; end
    end
    check("req_ready", 64'(req_ready), 64'(g));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", 64'(out_data), 64'(m_data));
    check("out_id", 64'(out_id), 64'(m_id));
    if (!rs && m_valid && rdy) begin
      check("sb_size", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_data", 64'(out_data), 64'(e[31:0]));
        check("sb_id", 64'(out_id), 64'(e[32]));
      end
    end
    if (rs) begin
      m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_ptr = 1'b0;
      sb.delete();
    end else if (|g) begin
      m_data = ext(gi ? d1 : d0, z[gi]);
      m_id = gi; m_valid = 1'b1; m_ptr = !gi;
      sb.push_back({gi, m_data});
    end else if (rdy) m_valid = 1'b0;
  endtask

  initial begin
    cyc(1, 2'b11, 16'h1234, 16'h5678, 1, 2'b00);
    cyc(1, 2'b11, 16'h1234, 16'h5678, 1, 2'b00);
    cyc(0, 2'b01, 16'h8000, 16'h0000, 1, 2'b00);
    cyc(0, 2'b10, 16'h0000, 16'h0C01, 1, 2'b00);
    cyc(0, 2'b00, 16'h0000, 16'h0000, 1, 2'b00);
    cyc(0, 2'b00, 16'h0000, 16'h0000, 1, 2'b00);
    for (int i = 0; i < 6; i++) cyc(0, 2'b11, 16'h0001, 16'hA4C0, 1, 2'b00);
    for (int i = 0; i < 5; i++) cyc(0, 2'b11, 16'h0001, 16'hA4C0, 0, 2'b00);
    cyc(0, 2'b11, 16'h0001, 16'hA4C0, 1, 2'b00);
    cyc(0, 2'b11, 16'h0001, 16'hA4C0, 0, 2'b00);
    cyc(1, 2'b11, 16'h0001, 16'hA4C0, 0, 2'b00);
    cyc(0, 2'b11, 16'h0001, 16'hA4C0, 1, 2'b00);
    cyc(0, 2'b00, 16'h0000, 16'h0000, 1, 2'b00);
`ifdef SE_ARB_ZERO_EXT_EN
    cyc(0, 2'b01, 16'h8000, 16'h0000, 1, 2'b01);
    cyc(0, 2'b01, 16'h8000, 16'h0000, 1, 2'b00);
    cyc(0, 2'b00, 16'h0000, 16'h0000, 1, 2'b00);
`endif
    for (int i = 0; i < 60; i++)
      cyc(0, 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0), 2'($urandom));
    cyc(0, 2'b00, 16'h0000, 16'h0000, 1, 2'b00);
    cyc(0, 2'b00, 16'h0000, 16'h0000, 1, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
